// File: rtl/cl_row_sched.sv
// cl_row_sched: Camera Link row-write sequencer and ping-pong frame-buffer selector.
// Optional row window via CL_ROW_SCHED_ROI_EN (adds iROW_FIRST/iROW_LAST).
module cl_row_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int ROW_MAX = 480,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  CCLK,
  input  logic                  RST,
  input  logic                  iFVAL,
  input  logic                  iLVAL,
  input  logic                  iDVAL,
  input  logic                  iENABLE,
  input  logic                  iWR_ACK,
  input  logic                  iRD_DONE,
`ifdef CL_ROW_SCHED_ROI_EN
  input  logic [ADDR_WIDTH-1:0] iROW_FIRST,
  input  logic [ADDR_WIDTH-1:0] iROW_LAST,
`endif
  output logic                  oLINE_LATCH,
  output logic                  oLINE_CLR,
  output logic                  oWR_REQ,
  output logic [ADDR_WIDTH-1:0] oWR_ROW,
  output logic                  oMEM_SEL,
  output logic                  oFRAME_DONE,
  output logic                  oDONE_SEL,
  output logic [CNT_WIDTH-1:0]  oLINE_DROP,
  output logic [CNT_WIDTH-1:0]  oFRAME_DROP
);
  typedef enum logic [1:0] {IDLE, ARMED, FRAME, FLUSH} f_state_t;
  typedef enum logic {W_IDLE, W_REQ} w_state_t;
  localparam logic [ADDR_WIDTH-1:0] RMAX = ADDR_WIDTH'(ROW_MAX);
  f_state_t f_st, f_nx;
  w_state_t w_st, w_nx;
  logic fval_q, dval_q, lval_q;
  logic fr, ff, le, start, le_f, port_free, in_win, wr_go, wr_drop, leave, rel;
  logic [ADDR_WIDTH-1:0] row, row_addr;
  assign fr = iFVAL && !fval_q;
  assign ff = !iFVAL && fval_q;
  assign le = dval_q && !iDVAL && lval_q;
  assign start = (f_st == ARMED) && fr;
  assign le_f = (f_st == FRAME) && le;
  assign port_free = (w_st == W_IDLE) || iWR_ACK;
  assign wr_go = le_f && in_win && port_free;
  assign wr_drop = le_f && in_win && !port_free;
  assign oWR_REQ = (w_st == W_REQ);
`ifdef CL_ROW_SCHED_ROI_EN
  logic [ADDR_WIDTH-1:0] first_q, last_q;
  assign in_win = (row >= first_q) && (row <= last_q) && (row < RMAX);
  assign row_addr = row - first_q;
  always_ff @(posedge CCLK)
    if (RST) begin
      first_q <= '0;
      last_q <= '0;
    end else if (start) begin
      first_q <= iROW_FIRST;
      last_q <= iROW_LAST;
    end
`else
  assign in_win = row < RMAX;
  assign row_addr = row;
`endif
  // Edge-detect history follows the inputs even in reset, so a frame already in progress is never seen as a fresh FR.
  always_ff @(posedge CCLK) begin
    fval_q <= iFVAL;
    dval_q <= iDVAL;
    lval_q <= iLVAL;
  end
  always_comb begin
    f_nx = f_st;
    leave = 1'b0;
    unique case (f_st)
      IDLE:  f_nx = iENABLE ? ARMED : IDLE;
      ARMED: f_nx = fr ? FRAME : (iENABLE ? ARMED : IDLE);
      FRAME: f_nx = ff ? FLUSH : FRAME;
      FLUSH: begin
        leave = port_free;
        f_nx = port_free ? (iENABLE ? ARMED : IDLE) : FLUSH;
      end
    endcase
  end
  always_comb begin
    w_nx = w_st;
    w_nx = wr_go ? W_REQ : (iWR_ACK ? W_IDLE : w_st);
  end
  always_ff @(posedge CCLK)
    if (RST) begin
      f_st <= IDLE;
      w_st <= W_IDLE;
      row <= '0;
      rel <= 1'b1;
      oLINE_LATCH <= 1'b0;
      oLINE_CLR <= 1'b0;
      oWR_ROW <= '0;
      oMEM_SEL <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oDONE_SEL <= 1'b0;
      oLINE_DROP <= '0;
      oFRAME_DROP <= '0;
    end else begin
      f_st <= f_nx;
      w_st <= w_nx;
      oLINE_LATCH <= wr_go;
      oLINE_CLR <= le_f || start;
      oFRAME_DONE <= leave;
      rel <= iRD_DONE || (rel && !leave);
      if (wr_go) oWR_ROW <= row_addr;
      if (start) row <= '0;
      else if (le_f && row != RMAX) row <= row + 1'b1;
      if (leave) oDONE_SEL <= oMEM_SEL;
      if (leave && rel) oMEM_SEL <= !oMEM_SEL;
      if (leave && !rel && !(&oFRAME_DROP)) oFRAME_DROP <= oFRAME_DROP + 1'b1;
      if (wr_drop && !(&oLINE_DROP)) oLINE_DROP <= oLINE_DROP + 1'b1;
    end
endmodule

// File: tb/tb_cl_row_sched.sv
// tb_cl_row_sched: directed self-checking bench for cl_row_sched (default and ROW_MAX=2 instances).
module tb_cl_row_sched;
  logic CCLK = 1'b0, RST = 1'b1;
  logic iFVAL = 1'b0, iLVAL = 1'b0, iDVAL = 1'b0, iENABLE = 1'b0, iWR_ACK = 1'b0, iRD_DONE = 1'b0;
  logic oLINE_LATCH, oLINE_CLR, oWR_REQ, oMEM_SEL, oFRAME_DONE, oDONE_SEL;
  logic [10:0] oWR_ROW;
  logic [15:0] oLINE_DROP, oFRAME_DROP;
  logic latch2, clr2, req2, sel2, done2, dsel2;
  logic [10:0] row2;
  logic [15:0] ldrop2, fdrop2;
  int checks = 0, errors = 0;
  int n_clr = 0, n_clr2 = 0, n_done = 0, hold_bad = 0, nd;
  logic last_sel = 1'b0, auto_ack = 1'b0, hold_chk = 1'b0;
  int rows[$], rows2[$];
  always #5 CCLK = ~CCLK;
  cl_row_sched u_dut (
    .CCLK(CCLK), .RST(RST), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDVAL(iDVAL),
    .iENABLE(iENABLE), .iWR_ACK(iWR_ACK), .iRD_DONE(iRD_DONE),
`ifdef CL_ROW_SCHED_ROI_EN
    .iROW_FIRST(11'd0), .iROW_LAST(11'h7ff),
`endif
    .oLINE_LATCH(oLINE_LATCH), .oLINE_CLR(oLINE_CLR), .oWR_REQ(oWR_REQ), .oWR_ROW(oWR_ROW),
    .oMEM_SEL(oMEM_SEL), .oFRAME_DONE(oFRAME_DONE), .oDONE_SEL(oDONE_SEL),
    .oLINE_DROP(oLINE_DROP), .oFRAME_DROP(oFRAME_DROP)
  );
  cl_row_sched #(.ROW_MAX(2)) u_dut2 (
    .CCLK(CCLK), .RST(RST), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDVAL(iDVAL),
    .iENABLE(iENABLE), .iWR_ACK(iWR_ACK), .iRD_DONE(iRD_DONE),
`ifdef CL_ROW_SCHED_ROI_EN
    .iROW_FIRST(11'd0), .iROW_LAST(11'h7ff),
`endif
    .oLINE_LATCH(latch2), .oLINE_CLR(clr2), .oWR_REQ(req2), .oWR_ROW(row2),
    .oMEM_SEL(sel2), .oFRAME_DONE(done2), .oDONE_SEL(dsel2),
    .oLINE_DROP(ldrop2), .oFRAME_DROP(fdrop2)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CCLK);
    #1;
    if (oLINE_CLR) n_clr++;
    if (clr2) n_clr2++;
    if (oLINE_LATCH) rows.push_back(int'(oWR_ROW));
    if (latch2) rows2.push_back(int'(row2));
    if (oFRAME_DONE) begin
      n_done++;
      last_sel = oDONE_SEL;
    end
    if (hold_chk && !(oWR_REQ && oWR_ROW == 11'd0)) hold_bad++;
    iWR_ACK = auto_ack && (oWR_REQ || req2);
  endtask
  task automatic line();
    iLVAL = 1'b1;
    iDVAL = 1'b1;
    repeat (4) step();
    iLVAL = 1'b0;
    iDVAL = 1'b0;
    repeat (3) step();
  endtask
  task automatic frame(input int nl);
    iFVAL = 1'b1;
    step();
    step();
    repeat (nl) line();
    iFVAL = 1'b0;
    repeat (6) step();
  endtask
  initial begin
    step();
    step();
    chk("reset_outs", {oLINE_LATCH, oLINE_CLR, oWR_REQ, oWR_ROW, oMEM_SEL, oFRAME_DONE, oDONE_SEL, oLINE_DROP, oFRAME_DROP}, 64'd0);
    RST = 1'b0;
    iENABLE = 1'b1;
    auto_ack = 1'b1;
    step();
    step();
    // Frame of 5 lines: full-size DUT writes all, ROW_MAX=2 DUT writes only rows 0 and 1.
    n_clr = 0;
    n_clr2 = 0;
    rows.delete();
    rows2.delete();
    frame(5);
    chk("t1_nrows", rows.size(), 5);
    for (int i = 0; i < 5; i++) chk("t1_row", rows[i], i);
    chk("t1_done", n_done, 1);
    chk("t1_done_sel", last_sel, 0);
    chk("t1_mem_sel", oMEM_SEL, 1);
    chk("t1_ldrop", oLINE_DROP, 0);
    chk("t1_fdrop", oFRAME_DROP, 0);
    chk("t1_clr", n_clr, 6);
    chk("rm2_nrows", rows2.size(), 2);
    chk("rm2_row0", rows2[0], 0);
    chk("rm2_row1", rows2[1], 1);
    chk("rm2_clr", n_clr2, 6);
    chk("rm2_ldrop", ldrop2, 0);
    // Ack withheld ~100 cycles while two more lines end.
    auto_ack = 1'b0;
    iFVAL = 1'b1;
    step();
    step();
    rows.delete();
    line();
    chk("t2_req", oWR_REQ, 1);
    chk("t2_row", oWR_ROW, 0);
    hold_chk = 1'b1;
    line();
    line();
    repeat (86) step();
    hold_chk = 1'b0;
    chk("t2_hold", hold_bad, 0);
    chk("t2_ldrop", oLINE_DROP, 2);
    iWR_ACK = 1'b1;
    step();
    chk("t2_req_fall", oWR_REQ, 0);
    auto_ack = 1'b1;
    line();
    chk("t2_nrows", rows.size(), 2);
    chk("t2_row_adv", rows[1], 3);
    iFVAL = 1'b0;
    repeat (6) step();
    chk("t3_done", n_done, 2);
    chk("t3_done_sel", last_sel, 1);
    chk("t3_mem_keep", oMEM_SEL, 1);
    chk("t3_fdrop", oFRAME_DROP, 1);
    iRD_DONE = 1'b1;
    step();
    iRD_DONE = 1'b0;
    frame(2);
    chk("t3b_done", n_done, 3);
    chk("t3b_done_sel", last_sel, 1);
    chk("t3b_mem_swap", oMEM_SEL, 0);
    chk("t3b_fdrop", oFRAME_DROP, 1);
    // DVAL and FVAL fall together: frame completes only after the last row is acked.
    auto_ack = 1'b0;
    iFVAL = 1'b1;
    step();
    step();
    iLVAL = 1'b1;
    iDVAL = 1'b1;
    repeat (4) step();
    iLVAL = 1'b0;
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    rows.delete();
    step();
    chk("t4_latch", oLINE_LATCH, 1);
    chk("t4_req", oWR_REQ, 1);
    nd = n_done;
    repeat (5) step();
    chk("t4_no_done", n_done, nd);
    chk("t4_req_hold", oWR_REQ, 1);
    iWR_ACK = 1'b1;
    step();
    chk("t4_done", oFRAME_DONE, 1);
    chk("t4_done_sel", oDONE_SEL, 0);
    chk("t4_req_fall", oWR_REQ, 0);
    chk("t4_mem_keep", oMEM_SEL, 0);
    chk("t4_fdrop", oFRAME_DROP, 2);
    // Reset during a pending request, then mid-frame re-arm must wait for a fresh FR.
    iFVAL = 1'b1;
    step();
    step();
    line();
    chk("t5_req", oWR_REQ, 1);
    RST = 1'b1;
    step();
    chk("t5_reset_outs", {oLINE_LATCH, oLINE_CLR, oWR_REQ, oWR_ROW, oMEM_SEL, oFRAME_DONE, oDONE_SEL, oLINE_DROP, oFRAME_DROP}, 64'd0);
    RST = 1'b0;
    repeat (3) step();
    chk("t5_no_done", n_done, 4);
    n_clr = 0;
    rows.delete();
    line();
    chk("t5_wait_req", oWR_REQ, 0);
    chk("t5_wait_rows", rows.size(), 0);
    chk("t5_wait_clr", n_clr, 0);
    iFVAL = 1'b0;
    step();
    step();
    iFVAL = 1'b1;
    step();
    step();
    line();
    chk("t5_req2", oWR_REQ, 1);
    chk("t5_row2", oWR_ROW, 0);
    iWR_ACK = 1'b1;
    step();
    auto_ack = 1'b1;
    iFVAL = 1'b0;
    repeat (6) step();
    chk("t5_done", n_done, 5);
    chk("t5_done_sel", last_sel, 0);
    chk("t5_rel_reset", oMEM_SEL, 1);
    chk("t5_fdrop", oFRAME_DROP, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
